load_mem_scheduler: RTL and testbench



---
 rtl/tomasulo_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/load_mem_scheduler.sv | 137 +++++++++++++
 tb/tb_load_mem_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants and scheduler state encoding, used by the
// load/store/ALU schedulers and the CDB arbiter.
package tomasulo_pkg;

  localparam int unsigned DEF_TAG_W  = 3;
  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned NO_TAG     = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    CDB  = 2'd2
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr,
// wrapping from N-1 to 0. ptr must be below N.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  logic [IDX_W:0] cand;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // ptr + k stays below 2N, so a single subtraction wraps it
      cand = {1'b0, ptr} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!any_valid && req[cand[IDX_W-1:0]]) begin
        any_valid                = 1'b1;
        grant[cand[IDX_W-1:0]]   = 1'b1;
        idx                      = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/load_mem_scheduler.sv
// Load scheduler: issues one ready load RS entry to the data memory, then
// broadcasts the result on the CDB. Optional macro LOAD_SCHED_TIMEOUT_EN.
module load_mem_scheduler
  import tomasulo_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = 3,
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TAG_W       = DEF_TAG_W
`ifdef LOAD_SCHED_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [NUM_ENTRIES-1:0]        entry_ready,
  input  logic [NUM_ENTRIES*ADDR_W-1:0] entry_addr,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_done,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          cdb_req,
  input  logic                          cdb_grant,
  output logic [TAG_W-1:0]              cdb_tag,
  output logic [DATA_W-1:0]             cdb_data,
  output logic [NUM_ENTRIES-1:0]        entry_issued,
  output logic [NUM_ENTRIES-1:0]        entry_free
`ifdef LOAD_SCHED_TIMEOUT_EN
  , output logic                        mem_timeout
`endif
);

  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  sched_state_e           state, state_nxt;
  logic [IDX_W-1:0]       ptr, idx;
  logic [NUM_ENTRIES-1:0] sel_grant;
  logic [IDX_W-1:0]       sel_idx;
  logic                   sel_valid;
  logic [ADDR_W-1:0]      addr_arr [NUM_ENTRIES];
  logic                   timeout_hit;
  logic                   issue, load_cdb, retire;
  logic [NUM_ENTRIES-1:0] free_nxt;

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_addr
    assign addr_arr[g] = entry_addr[g*ADDR_W +: ADDR_W];
  end

  rr_arbiter #(.N(NUM_ENTRIES), .IDX_W(IDX_W)) u_rr (
    .req       (entry_ready),
    .ptr       (ptr),
    .grant     (sel_grant),
    .idx       (sel_idx),
    .any_valid (sel_valid)
  );

`ifdef LOAD_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (state == MEM) && !mem_done &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Counts MEM cycles; held at zero outside MEM so each load starts fresh
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      mem_timeout <= timeout_hit;
      wait_cnt    <= (state == MEM) ? wait_cnt + CNT_W'(1) : '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_valid) state_nxt = MEM;
      MEM:     if (mem_done || timeout_hit) state_nxt = CDB;
      CDB:     if (cdb_grant) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake events qualified by state; stray mem_done/cdb_grant fall out here
  always_comb begin
    issue    = 1'b0;
    load_cdb = 1'b0;
    retire   = 1'b0;
    free_nxt = '0;
    case (state)
      IDLE:    issue    = sel_valid;
      MEM:     load_cdb = mem_done || timeout_hit;
      CDB:     retire   = cdb_grant;
      default: ;
    endcase
    free_nxt[idx] = retire;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      cdb_req      <= 1'b0;
      cdb_tag      <= TAG_W'(NO_TAG);
      cdb_data     <= '0;
      entry_issued <= '0;
      entry_free   <= '0;
      idx          <= '0;
      ptr          <= '0;
    end else begin
      mem_req      <= (state_nxt == MEM);
      cdb_req      <= (state_nxt == CDB);
      entry_issued <= issue ? sel_grant : '0;
      entry_free   <= free_nxt;
      if (issue) begin
        idx      <= sel_idx;
        mem_addr <= addr_arr[sel_idx];
      end
      if (load_cdb) begin
        cdb_tag  <= TAG_W'(idx) + TAG_W'(1);
        cdb_data <= mem_done ? mem_data : '0;
      end
      if (retire) ptr <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_load_mem_scheduler.sv
// Directed bench for load_mem_scheduler (default build, 3 entries).
`timescale 1ns/1ps
module tb_load_mem_scheduler;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  entry_ready = '0;
  logic [47:0] entry_addr = {16'h0300, 16'h0040, 16'h0010};
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [15:0] mem_data = '0;
  logic        cdb_req;
  logic        cdb_grant = 1'b0;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [2:0]  entry_issued;
  logic [2:0]  entry_free;

  int checks = 0;
  int errors = 0;

  load_mem_scheduler dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .entry_ready  (entry_ready),
    .entry_addr   (entry_addr),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_done     (mem_done),
    .mem_data     (mem_data),
    .cdb_req      (cdb_req),
    .cdb_grant    (cdb_grant),
    .cdb_tag      (cdb_tag),
    .cdb_data     (cdb_data),
    .entry_issued (entry_issued),
    .entry_free   (entry_free)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  rdy;
    logic        done;
    logic [15:0] data;
    logic        grant;
    logic        mr;
    logic [15:0] ma;
    logic        cr;
    logic [2:0]  ct;
    logic [15:0] cd;
    logic [2:0]  iss;
    logic [2:0]  fr;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] r, input logic d, input logic [15:0] dat, input logic g);
    entry_ready = r;
    mem_done    = d;
    mem_data    = dat;
    cdb_grant   = g;
    @(posedge clock);
    #1;
  endtask

  // Address/tag/data only compared while their request is expected high
  task automatic expect_all(input string nm, input logic mr, input logic [15:0] ma,
                            input logic cr, input logic [2:0] ct, input logic [15:0] cd,
                            input logic [2:0] iss, input logic [2:0] fr);
    chk({nm, " mem_req"}, 32'(mem_req), 32'(mr));
    if (mr) chk({nm, " mem_addr"}, 32'(mem_addr), 32'(ma));
    chk({nm, " cdb_req"}, 32'(cdb_req), 32'(cr));
    if (cr) begin
      chk({nm, " cdb_tag"}, 32'(cdb_tag), 32'(ct));
      chk({nm, " cdb_data"}, 32'(cdb_data), 32'(cd));
    end
    chk({nm, " entry_issued"}, 32'(entry_issued), 32'(iss));
    chk({nm, " entry_free"}, 32'(entry_free), 32'(fr));
  endtask

  initial begin
    // Round-robin with everything always ready/answered, then a single load
    vecs[0]  = '{3'b111, 1'b1, 16'hA000, 1'b1, 1'b1, 16'h0010, 1'b0, 3'd0, 16'h0000, 3'b001, 3'b000};
    vecs[1]  = '{3'b111, 1'b1, 16'hA001, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd1, 16'hA001, 3'b000, 3'b000};
    vecs[2]  = '{3'b111, 1'b1, 16'hA002, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'b000, 3'b001};
    vecs[3]  = '{3'b111, 1'b1, 16'hA003, 1'b1, 1'b1, 16'h0040, 1'b0, 3'd0, 16'h0000, 3'b010, 3'b000};
    vecs[4]  = '{3'b111, 1'b1, 16'hA004, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd2, 16'hA004, 3'b000, 3'b000};
    vecs[5]  = '{3'b111, 1'b1, 16'hA005, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'b000, 3'b010};
    vecs[6]  = '{3'b111, 1'b1, 16'hA006, 1'b1, 1'b1, 16'h0300, 1'b0, 3'd0, 16'h0000, 3'b100, 3'b000};
    vecs[7]  = '{3'b111, 1'b1, 16'hA007, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd3, 16'hA007, 3'b000, 3'b000};
    vecs[8]  = '{3'b111, 1'b1, 16'hA008, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'b000, 3'b100};
    vecs[9]  = '{3'b111, 1'b1, 16'hA009, 1'b1, 1'b1, 16'h0010, 1'b0, 3'd0, 16'h0000, 3'b001, 3'b000};
    vecs[10] = '{3'b111, 1'b1, 16'hA00A, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd1, 16'hA00A, 3'b000, 3'b000};
    vecs[11] = '{3'b111, 1'b1, 16'hA00B, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'b000, 3'b001};
    vecs[12] = '{3'b000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'b000, 3'b000};
    vecs[13] = '{3'b010, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 1'b0, 3'd0, 16'h0000, 3'b010, 3'b000};
    vecs[14] = '{3'b010, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 1'b0, 3'd0, 16'h0000, 3'b000, 3'b000};
    vecs[15] = '{3'b010, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0040, 1'b0, 3'd0, 16'h0000, 3'b000, 3'b000};
    vecs[16] = '{3'b010, 1'b1, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd2, 16'hBEEF, 3'b000, 3'b000};
    vecs[17] = '{3'b000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd2, 16'hBEEF, 3'b000, 3'b000};
    vecs[18] = '{3'b000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'b000, 3'b010};
    vecs[19] = '{3'b000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'b000, 3'b000};

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst cdb_req", 32'(cdb_req), 32'd0);
    chk("rst cdb_tag", 32'(cdb_tag), 32'd0);
    chk("rst cdb_data", 32'(cdb_data), 32'd0);
    chk("rst entry_issued", 32'(entry_issued), 32'd0);
    chk("rst entry_free", 32'(entry_free), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rdy, vecs[i].done, vecs[i].data, vecs[i].grant);
      expect_all($sformatf("vec%0d", i), vecs[i].mr, vecs[i].ma, vecs[i].cr,
                 vecs[i].ct, vecs[i].cd, vecs[i].iss, vecs[i].fr);
    end

    // CDB stall; pointer sits at 2, so entry 0 is found by wrapping
    step(3'b001, 1'b0, 16'h0000, 1'b0);
    expect_all("stall issue", 1'b1, 16'h0010, 1'b0, 3'd0, 16'h0, 3'b001, 3'b000);
    step(3'b111, 1'b1, 16'h1234, 1'b0);
    expect_all("stall load", 1'b0, 16'h0, 1'b1, 3'd1, 16'h1234, 3'b000, 3'b000);
    for (int i = 0; i < 5; i++) begin
      step(3'b111, i[0], 16'hFFFF, 1'b0);
      expect_all($sformatf("stall%0d", i), 1'b0, 16'h0, 1'b1, 3'd1, 16'h1234, 3'b000, 3'b000);
    end
    step(3'b111, 1'b0, 16'h0000, 1'b1);
    expect_all("stall grant", 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 3'b000, 3'b001);
    step(3'b111, 1'b0, 16'h0000, 1'b0);
    expect_all("stall next", 1'b1, 16'h0040, 1'b0, 3'd0, 16'h0, 3'b010, 3'b000);
    step(3'b111, 1'b0, 16'h0000, 1'b0);
    expect_all("mem hold", 1'b1, 16'h0040, 1'b0, 3'd0, 16'h0, 3'b000, 3'b000);

    // Asynchronous reset while a load is in MEM
    reset_n = 1'b0;
    #1;
    chk("async rst mem_req", 32'(mem_req), 32'd0);
    chk("async rst cdb_req", 32'(cdb_req), 32'd0);
    @(posedge clock);
    #1;
    chk("held rst mem_req", 32'(mem_req), 32'd0);
    reset_n = 1'b1;
    step(3'b011, 1'b0, 16'h0000, 1'b0);
    expect_all("post rst ptr0", 1'b1, 16'h0010, 1'b0, 3'd0, 16'h0, 3'b001, 3'b000);
    step(3'b000, 1'b1, 16'h5A5A, 1'b0);
    expect_all("post rst load", 1'b0, 16'h0, 1'b1, 3'd1, 16'h5A5A, 3'b000, 3'b000);
    step(3'b000, 1'b0, 16'h0000, 1'b1);
    expect_all("post rst free", 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 3'b000, 3'b001);
    step(3'b100, 1'b0, 16'h0000, 1'b0);
    expect_all("tag3 issue", 1'b1, 16'h0300, 1'b0, 3'd0, 16'h0, 3'b100, 3'b000);
    step(3'b000, 1'b1, 16'hC0DE, 1'b0);
    expect_all("tag3 load", 1'b0, 16'h0, 1'b1, 3'd3, 16'hC0DE, 3'b000, 3'b000);
    step(3'b000, 1'b0, 16'h0000, 1'b1);
    expect_all("tag3 free", 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 3'b000, 3'b100);

    // Spurious mem_done/cdb_grant in IDLE, then cdb_grant in MEM
    for (int i = 0; i < 3; i++) begin
      step(3'b000, 1'b1, 16'hDEAD, 1'b1);
      expect_all($sformatf("spur idle%0d", i), 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 3'b000, 3'b000);
    end
    step(3'b010, 1'b0, 16'h0000, 1'b0);
    expect_all("spur issue", 1'b1, 16'h0040, 1'b0, 3'd0, 16'h0, 3'b010, 3'b000);
    for (int i = 0; i < 2; i++) begin
      step(3'b000, 1'b0, 16'h0000, 1'b1);
      expect_all($sformatf("spur mem%0d", i), 1'b1, 16'h0040, 1'b0, 3'd0, 16'h0, 3'b000, 3'b000);
    end
    step(3'b000, 1'b1, 16'h7777, 1'b0);
    expect_all("spur load", 1'b0, 16'h0, 1'b1, 3'd2, 16'h7777, 3'b000, 3'b000);
    step(3'b000, 1'b0, 16'h0000, 1'b1);
    expect_all("spur free", 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 3'b000, 3'b010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
